// File: rtl/sync_bus_tx_if.sv
// Bus bundle for sync_bus_tx: clka-side valid/ready source handshake plus the
// held data word and req/ack toggle pair that cross toward the clkb capture side.
interface sync_bus_tx_if #(
    parameter int BUS_WIDTH = 8
);
    logic                 in_valid;
    logic [BUS_WIDTH-1:0] in_data;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] tx_data;
    logic                 req_t;
    logic                 ack_t;
    logic                 busy;
    logic                 done;
    logic                 err;

    // master: the launcher itself; slave: the clka source plus clkb capture side
    modport master (
        input  in_valid, in_data, ack_t,
        output in_ready, tx_data, req_t, busy, done, err
    );

    modport slave (
        output in_valid, in_data, ack_t,
        input  in_ready, tx_data, req_t, busy, done, err
    );
endinterface

// File: rtl/sync_bus_tx.sv
// Source-side launcher for a clka->clkb 2-phase toggle crossing: holds a word on
// tx_data, toggles req_t, waits for the resynchronised ack. Optional: SYNC_TX_TIMEOUT_EN.
module sync_bus_tx #(
    parameter int                   BUS_WIDTH      = 8,
    parameter logic [BUS_WIDTH-1:0] RESET_VAL      = '0,
    parameter int                   SYNC_STAGE     = 2,
    parameter int                   TIMEOUT_CYCLES = 1024
) (
    input  logic          clka,
    input  logic          clka_rst_n,
    sync_bus_tx_if.master bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    if (SYNC_STAGE < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sync_bus_tx: SYNC_STAGE must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t                state;
    state_t                state_next;
    logic [SYNC_STAGE-1:0] ack_sync;
    logic                  ack_s;
    logic                  accept;
    logic                  ack_seen;
    logic [BUS_WIDTH-1:0]  tx_data_q;
    logic                  req_q;
    logic                  done_q;

    // NOTE: every flop here, including the synchroniser chain, takes a reset value;
    // a clean chain is what keeps req/ack toggle parity aligned with the clkb side.
    always_ff @(posedge clka or negedge clka_rst_n) begin
        if (!clka_rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGE-2:0], bus.ack_t};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGE-1];

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ack_seen   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_s == req_q) begin
                    ack_seen   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clka or negedge clka_rst_n) begin
        if (!clka_rst_n) begin
            state     <= ST_IDLE;
            tx_data_q <= RESET_VAL;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= ack_seen;
            // data and toggle move on the same edge, so data leads the receiver's pulse
            if (accept) begin
                tx_data_q <= bus.in_data;
                req_q     <= ~req_q;
            end
        end
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.busy     = (state == ST_WAIT);
    assign bus.tx_data  = tx_data_q;
    assign bus.req_t    = req_q;
    assign bus.done     = done_q;

`ifdef SYNC_TX_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // the transfer is never aborted: the counter saturates and err stays set
    always_ff @(posedge clka or negedge clka_rst_n) begin
        if (!clka_rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == ST_WAIT && wait_cnt == CNT_MAX) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_sync_bus_tx.sv
// Self-checking bench for sync_bus_tx: scoreboard of accepted words checked at the
// modelled clkb capture point, plus latency, hold, spurious-ack, reset and timeout scenarios.
module tb_sync_bus_tx;
    localparam int             BW  = 8;
    localparam logic [BW-1:0]  RV  = 8'h5A;
    localparam int             SS  = 2;
    localparam int             TO  = 16;
`ifdef SYNC_TX_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clka = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;
    logic exp_req = 1'b0;
    logic [BW-1:0] sb[$];

    sync_bus_tx_if #(.BUS_WIDTH(BW)) bus();

    sync_bus_tx #(
        .BUS_WIDTH     (BW),
        .RESET_VAL     (RV),
        .SYNC_STAGE    (SS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clka      (clka),
        .clka_rst_n(rst_n),
        .bus       (bus.master)
    );

    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ack_t    = 1'b0;
        exp_req      = 1'b0;
        sb.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [BW-1:0] d);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        sb.push_back(d);
        exp_req = ~exp_req;
        vectors++;
        if (bus.req_t !== exp_req) begin
            errors++;
            $display("FAIL accept_req: req_t=%b required %b", bus.req_t, exp_req);
        end
        vectors++;
        if ({bus.in_ready, bus.busy} !== 2'b01) begin
            errors++;
            $display("FAIL accept_state: in_ready,busy=%b required 01", {bus.in_ready, bus.busy});
        end
    endtask

    // Models the clkb side: capture tx_data, return the ack toggle, await done.
    task automatic finish_xfer(input bit check_pulse);
        logic [BW-1:0] e;
        int            n;
        bit            seen;
        vectors++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL capture_empty: scoreboard empty, tx_data=%h", bus.tx_data);
        end else begin
            e = sb.pop_front();
            if (bus.tx_data !== e) begin
                errors++;
                $display("FAIL capture_data: tx_data=%h required %h", bus.tx_data, e);
            end
        end
        bus.ack_t = ~bus.ack_t;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || n != SS + 1) begin
            errors++;
            $display("FAIL done_latency: seen=%0b after %0d edges, required %0d", seen, n, SS + 1);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_ready: in_ready=%b required 1", bus.in_ready);
        end
        if (check_pulse) begin
            tick();
            vectors++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b required 0 one cycle later", bus.done);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.req_t !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
        end
        vectors++;
        if (bus.tx_data !== RV) begin
            errors++;
            $display("FAIL reset_data: tx_data=%h required %h", bus.tx_data, RV);
        end
        vectors++;
        if ({bus.busy, bus.err} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy,err=%b required 00", {bus.busy, bus.err});
        end
    endtask

    task automatic test_basic();
        send_word(8'hA5);
        finish_xfer(1'b1);
    endtask

    task automatic test_hold();
        do_reset();
        send_word(8'h3C);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (5) tick();
        vectors++;
        if (bus.tx_data !== 8'h3C || bus.req_t !== exp_req || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait: tx_data=%h req_t=%b in_ready=%b required 3c %b 0",
                     bus.tx_data, bus.req_t, bus.in_ready, exp_req);
        end
        bus.in_valid = 1'b0;
        finish_xfer(1'b1);
        send_word(8'hFF);
        vectors++;
        if (bus.req_t !== 1'b0) begin
            errors++;
            $display("FAIL hold_req_back: req_t=%b required 0", bus.req_t);
        end
        finish_xfer(1'b1);
    endtask

    task automatic test_spurious();
        int bad;
        bad = 0;
        repeat (2) begin
            bus.ack_t = ~bus.ack_t;
            repeat (6) begin
                tick();
                if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.req_t !== exp_req) bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spurious_ack: %0d bad cycles, required 0", bad);
        end
        send_word(8'h77);
        finish_xfer(1'b1);
    endtask

    task automatic test_back_to_back();
        send_word(8'h11);
        finish_xfer(1'b0);
        send_word(8'h22);
        finish_xfer(1'b0);
        send_word(8'h33);
        finish_xfer(1'b1);
    endtask

    task automatic test_reset_mid_wait();
        send_word(8'hC3);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.req_t !== 1'b0 || bus.tx_data !== RV || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: req_t=%b tx_data=%h in_ready=%b busy=%b required 0 %h 1 0",
                     bus.req_t, bus.tx_data, bus.in_ready, bus.busy, RV);
        end
        sb.delete();
        bus.ack_t = 1'b0;
        exp_req   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_word(8'h96);
        finish_xfer(1'b1);
    endtask

    task automatic test_timeout();
        send_word(8'h4E);
        repeat (5) tick();
        vectors++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b required 0", bus.err);
        end
        repeat (20) tick();
        vectors++;
        if (bus.err !== EXP_ERR || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b required %b 1", bus.err, bus.busy, EXP_ERR);
        end
        finish_xfer(1'b1);
        send_word(8'hB2);
        finish_xfer(1'b1);
        vectors++;
        if (bus.err !== EXP_ERR) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b required %b", bus.err, EXP_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_spurious();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
